// File: rtl/trap_ctrl.sv
// Pipeline control: stall merge, trap/interrupt detection, CSR save/restore sequencing and
// PC redirect for the 6-stage core.
module trap_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_req_if_i,
  input  logic                  stall_req_id_i,
  input  logic                  stall_req_ex_i,
  input  logic                  stall_req_mem_i,
  input  logic [31:0]           exception_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  input  logic                  irq_timer_i,
  input  logic                  irq_ext_i,
  input  logic [31:0]           mstatus_i,
  input  logic [31:0]           mie_i,
  input  logic [31:0]           mtvec_i,
  input  logic [31:0]           mepc_i,
  output logic [5:0]            stall_o,
  output logic                  flush_int_o,
  output logic                  pc_we_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  csr_we_o,
  output logic [11:0]           csr_waddr_o,
  output logic [31:0]           csr_wdata_o
);

  typedef enum logic [2:0] {StIdle, StMepc, StMcause, StMstat, StMret, StJump} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             cause_q, cause_d;
  logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
  logic [31:0]             mstatus_q, mstatus_d;
  logic                    mret_q, mret_d;

  logic                    trap_en;
  logic                    trap_valid;
  logic                    trap_is_mret;
  logic [31:0]             trap_cause;
  logic                    irq_ext_take;
  logic                    irq_timer_take;

  logic unused_bits;
  assign unused_bits = ^{exception_i[31:4], mie_i[31:12], mie_i[10:8], mie_i[6:0], mtvec_i[1:0]};

  // A stalled MEM stage or a bubble cannot be the faulting/interrupted instruction.
  assign trap_en        = !stall_req_mem_i && (inst_addr_i != '0);
  assign irq_ext_take   = irq_ext_i & mstatus_i[3] & mie_i[11];
  assign irq_timer_take = irq_timer_i & mstatus_i[3] & mie_i[7];

  always_comb begin
    trap_valid   = 1'b0;
    trap_is_mret = 1'b0;
    trap_cause   = '0;
    if (trap_en) begin
      if (exception_i[0]) begin
        trap_valid = 1'b1;
        trap_cause = 32'd11;
      end else if (exception_i[1]) begin
        trap_valid = 1'b1;
        trap_cause = 32'd3;
      end else if (exception_i[2]) begin
        trap_valid = 1'b1;
        trap_cause = 32'd2;
      end else if (exception_i[3]) begin
        trap_valid   = 1'b1;
        trap_is_mret = 1'b1;
      end else if (irq_ext_take) begin
        trap_valid = 1'b1;
        trap_cause = 32'h8000_000B;
      end else if (irq_timer_take) begin
        trap_valid = 1'b1;
        trap_cause = 32'h8000_0007;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    mstatus_d   = mstatus_q;
    mret_d      = mret_q;
    stall_o     = '0;
    flush_int_o = 1'b0;
    pc_we_o     = 1'b0;
    new_pc_o    = '0;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;

    unique case (state_q)
      StIdle: begin
        if (trap_valid) begin
          flush_int_o = 1'b1;
          cause_d     = trap_cause;
          epc_d       = inst_addr_i;
          mstatus_d   = mstatus_i;
          mret_d      = trap_is_mret;
          state_d     = trap_is_mret ? StMret : StMepc;
        end else if (stall_req_mem_i) begin
          stall_o = 6'b011111;
        end else if (stall_req_ex_i) begin
          stall_o = 6'b001111;
        end else if (stall_req_id_i) begin
          stall_o = 6'b000111;
        end else if (stall_req_if_i) begin
          stall_o = 6'b000011;
        end
      end
      StMepc: begin
        flush_int_o = 1'b1;
        stall_o     = 6'b111111;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = 32'(epc_q);
        state_d     = StMcause;
      end
      StMcause: begin
        flush_int_o = 1'b1;
        stall_o     = 6'b111111;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
        state_d     = StMstat;
      end
      StMstat: begin
        flush_int_o    = 1'b1;
        stall_o        = 6'b111111;
        csr_we_o       = 1'b1;
        csr_waddr_o    = CSR_MSTATUS;
        csr_wdata_o    = mstatus_q;
        csr_wdata_o[7] = mstatus_q[3];
        csr_wdata_o[3] = 1'b0;
        state_d        = StJump;
      end
      StMret: begin
        flush_int_o    = 1'b1;
        stall_o        = 6'b111111;
        csr_we_o       = 1'b1;
        csr_waddr_o    = CSR_MSTATUS;
        csr_wdata_o    = mstatus_q;
        csr_wdata_o[3] = mstatus_q[7];
        csr_wdata_o[7] = 1'b1;
        state_d        = StJump;
      end
      StJump: begin
        flush_int_o = 1'b1;
        pc_we_o     = 1'b1;
        new_pc_o    = mret_q ? ADDR_WIDTH'(mepc_i) : ADDR_WIDTH'({mtvec_i[31:2], 2'b00});
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs must drop the moment reset asserts, even while IDLE sees a trap or stall request.
    if (rst_i) begin
      stall_o     = '0;
      flush_int_o = 1'b0;
      pc_we_o     = 1'b0;
      new_pc_o    = '0;
      csr_we_o    = 1'b0;
      csr_waddr_o = '0;
      csr_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cause_q   <= '0;
      epc_q     <= '0;
      mstatus_q <= '0;
      mret_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      mstatus_q <= mstatus_d;
      mret_q    <= mret_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected CSR/PC write events are queued by the stimulus and
// popped by a monitor whenever the DUT writes.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i;
  logic [31:0] exception_i, inst_addr_i;
  logic        irq_timer_i, irq_ext_i;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic [5:0]  stall_o;
  logic        flush_int_o, pc_we_o, csr_we_o;
  logic [31:0] new_pc_o, csr_wdata_o;
  logic [11:0] csr_waddr_o;

  trap_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_req_if_i (stall_req_if_i),
    .stall_req_id_i (stall_req_id_i),
    .stall_req_ex_i (stall_req_ex_i),
    .stall_req_mem_i(stall_req_mem_i),
    .exception_i    (exception_i),
    .inst_addr_i    (inst_addr_i),
    .irq_timer_i    (irq_timer_i),
    .irq_ext_i      (irq_ext_i),
    .mstatus_i      (mstatus_i),
    .mie_i          (mie_i),
    .mtvec_i        (mtvec_i),
    .mepc_i         (mepc_i),
    .stall_o        (stall_o),
    .flush_int_o    (flush_int_o),
    .pc_we_o        (pc_we_o),
    .new_pc_o       (new_pc_o),
    .csr_we_o       (csr_we_o),
    .csr_waddr_o    (csr_waddr_o),
    .csr_wdata_o    (csr_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        is_pc;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got, mon_exp;
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: every CSR or PC write must match the next queued expectation, cycle included.
  always @(negedge clk_i) begin
    if (!rst_i && (csr_we_o || pc_we_o)) begin
      mon_got.is_pc = pc_we_o;
      mon_got.addr  = csr_waddr_o;
      mon_got.data  = pc_we_o ? new_pc_o : csr_wdata_o;
      mon_got.cyc   = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got pc=%0b addr=%h data=%h cyc=%0d, required no write",
                 mon_got.is_pc, mon_got.addr, mon_got.data, mon_got.cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got != mon_exp) begin
          bad++;
          $display("FAIL write_event: got pc=%0b addr=%h data=%h cyc=%0d, required pc=%0b addr=%h data=%h cyc=%0d",
                   mon_got.is_pc, mon_got.addr, mon_got.data, mon_got.cyc,
                   mon_exp.is_pc, mon_exp.addr, mon_exp.data, mon_exp.cyc);
        end
      end
    end
  end

  function automatic void push(input logic is_pc, input logic [11:0] a, input logic [31:0] d,
                               input int c);
    ev_t e;
    e.is_pc = is_pc;
    e.addr  = a;
    e.data  = d;
    e.cyc   = c;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Called right after the trapping inputs are driven in the detect cycle.
  task automatic run_trap(input bit is_mret, input bit clr_irq, input logic [31:0] epc,
                          input logic [31:0] cause, input logic [31:0] mst,
                          input logic [31:0] pc);
    int c;
    int n;
    c = cyc;
    n = is_mret ? 2 : 4;
    if (is_mret) begin
      push(1'b0, 12'h300, mst, c + 1);
      push(1'b1, 12'h000, pc, c + 2);
    end else begin
      push(1'b0, 12'h341, epc, c + 1);
      push(1'b0, 12'h342, cause, c + 2);
      push(1'b0, 12'h300, mst, c + 3);
      push(1'b1, 12'h000, pc, c + 4);
    end
    #1;
    chk("detect_flush", 64'(flush_int_o), 64'd1);
    chk("detect_stall", 64'(stall_o), 64'd0);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 1) begin
        exception_i = '0;
        if (clr_irq) begin
          irq_timer_i = 1'b0;
          irq_ext_i   = 1'b0;
        end
      end
      #1;
      chk("seq_flush", 64'(flush_int_o), 64'd1);
      chk("seq_stall", 64'(stall_o), (k < n) ? 64'h3f : 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    stall_req_if_i = 1'b1; stall_req_id_i = 1'b0; stall_req_ex_i = 1'b0; stall_req_mem_i = 1'b0;
    exception_i = 32'h1; inst_addr_i = 32'h100;
    irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    mstatus_i = 32'h8; mie_i = '0; mtvec_i = 32'h204; mepc_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs", 64'({stall_o, flush_int_o, pc_we_o, csr_we_o, csr_waddr_o, csr_wdata_o}),
        64'd0);
    chk("reset_new_pc", 64'(new_pc_o), 64'd0);
    stall_req_if_i = 1'b0; exception_i = '0; inst_addr_i = '0;
    step();
    rst_i = 1'b0;
    step();

    // Stall merge priorities.
    stall_req_ex_i = 1'b1; stall_req_if_i = 1'b1; #1;
    chk("stall_ex_if", 64'(stall_o), 64'h0f);
    stall_req_mem_i = 1'b1; #1;
    chk("stall_mem", 64'(stall_o), 64'h1f);
    stall_req_mem_i = 1'b0; stall_req_ex_i = 1'b0; stall_req_id_i = 1'b1; #1;
    chk("stall_id", 64'(stall_o), 64'h07);
    stall_req_id_i = 1'b0; #1;
    chk("stall_if", 64'(stall_o), 64'h03);
    chk("stall_no_flush", 64'(flush_int_o), 64'd0);
    stall_req_if_i = 1'b0;

    // ecall at 0x100.
    step();
    exception_i = 32'h1; inst_addr_i = 32'h100; mstatus_i = 32'h8; mtvec_i = 32'h204;
    run_trap(1'b0, 1'b1, 32'h100, 32'd11, 32'h80, 32'h204);
    step(); #1;
    chk("ecall_done_flush", 64'(flush_int_o), 64'd0);

    // Bubble never traps.
    exception_i = 32'h1; inst_addr_i = 32'h0; #1;
    chk("bubble_no_trap", 64'(flush_int_o), 64'd0);
    exception_i = '0;

    // Timer masked by MIE=0, then taken.
    irq_timer_i = 1'b1; mie_i = 32'h80; mstatus_i = 32'h0; inst_addr_i = 32'h140;
    mtvec_i = 32'h301;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("timer_masked", 64'(flush_int_o), 64'd0);
    end
    step();
    mstatus_i = 32'h8;
    run_trap(1'b0, 1'b1, 32'h140, 32'h8000_0007, 32'h80, 32'h300);

    // ecall and external irq together: exception first, irq right after returning to IDLE.
    step();
    mie_i = 32'h800; mstatus_i = 32'h8; mtvec_i = 32'h204;
    irq_ext_i = 1'b1; exception_i = 32'h1; inst_addr_i = 32'h200;
    run_trap(1'b0, 1'b0, 32'h200, 32'd11, 32'h80, 32'h204);
    step();
    run_trap(1'b0, 1'b1, 32'h200, 32'h8000_000B, 32'h80, 32'h204);

    // mret with MPIE=1.
    step();
    exception_i = 32'h8; mstatus_i = 32'h80; mepc_i = 32'h180; inst_addr_i = 32'h240;
    run_trap(1'b1, 1'b1, 32'h0, 32'h0, 32'h88, 32'h180);

    // ecall deferred while MEM stalls.
    step();
    exception_i = 32'h1; inst_addr_i = 32'h300; stall_req_mem_i = 1'b1; mstatus_i = 32'h8;
    #1;
    chk("defer_flush", 64'(flush_int_o), 64'd0);
    chk("defer_stall", 64'(stall_o), 64'h1f);
    step(); #1;
    chk("defer_flush2", 64'(flush_int_o), 64'd0);
    step();
    stall_req_mem_i = 1'b0;
    run_trap(1'b0, 1'b1, 32'h300, 32'd11, 32'h80, 32'h204);

    // Reset during MCAUSE: only the mepc write may appear.
    step();
    exception_i = 32'h1; inst_addr_i = 32'h400;
    push(1'b0, 12'h341, 32'h400, cyc + 1);
    step();
    exception_i = '0; inst_addr_i = '0;
    step();
    rst_i = 1'b1; #1;
    chk("rst_mid_outputs", 64'({stall_o, flush_int_o, pc_we_o, csr_we_o, csr_waddr_o, csr_wdata_o}),
        64'd0);
    step();
    rst_i = 1'b0; #1;
    chk("rst_release_flush", 64'(flush_int_o), 64'd0);
    for (int i = 0; i < 4; i++) step();
    chk("rst_release_idle", 64'(flush_int_o), 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
